pulse_train_gen: RTL and testbench

Generates a train of exactly COUNT pulses spread evenly across a measurement window of WIN+1 prescaled ticks. It is the stimulus side of the pulse-counting encoder path. Its PULSE_OUT drives the encoder's pulse input, either in self-test or as an encoder emulator, so that a known count can be read back per window. Pulse placement uses a DDA accumulator, so spacing is as uniform as integer slots allow.

---
 rtl/pulse_train_gen_pkg.sv | 22 ++
 rtl/pulse_train_gen_tick_prescaler.sv | 44 ++++
 rtl/pulse_train_gen.sv | 136 +++++++++++++
 tb/tb_pulse_train_gen.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_train_gen_pkg.sv
// Shared types and constants for the pulse train generator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pulse_train_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_DIV = 250;
  localparam int DEF_W   = 8;

  // Two guard bits let acc + COUNT_L and WIN_L + 1 be formed without overflow.
  localparam int ACC_GUARD = 2;
  localparam int DEF_ACC_W = DEF_W + ACC_GUARD;

  function automatic int acc_width(input int w);
    return w + ACC_GUARD;
  endfunction

endpackage

// File: rtl/pulse_train_gen_tick_prescaler.sv
// Slot prescaler: free-running tick counter 0..DIV-1 while enabled, held at 0 otherwise.
// Latency: decode outputs are combinational from the registered tick count.
// Backpressure: none; counts every CLK while EN is high.
//
// Ports:
//   CLK, RST    - clock and synchronous active-high reset
//   EN          - count enable (block is in RUN)
//   tick_wrap   - tick == DIV-1 (last cycle of a slot)
//   first_half  - tick <  DIV/2 (pulse-high portion of a slot)
//   slot_start  - tick == 0     (first cycle of a slot)
module tick_prescaler #(
  parameter int DIV = 250
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  output logic tick_wrap,
  output logic first_half,
  output logic slot_start
);

  localparam int TW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(DIV / 2);

  logic [TW-1:0] tick;

  always_ff @(posedge CLK) begin
    if (RST) begin
      tick <= '0;
    end else if (!EN) begin
      tick <= '0;
    end else if (tick == TICK_LAST) begin
      tick <= '0;
    end else begin
      tick <= tick + TW'(1);
    end
  end

  assign tick_wrap  = (tick == TICK_LAST);
  assign first_half = (tick < TICK_HALF);
  assign slot_start = (tick == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Emits exactly COUNT_L pulses spread over WIN_L+1 slots per window using a DDA accumulator.
// Latency: EN sampled in IDLE -> WIN_STRB and slot 0 on the next CLK; PULSE_OUT decoded from registers.
// Backpressure: none; free-running once started, a window always completes unless RST.
//
// Ports:
//   CLK, RST   - clock and synchronous active-high reset
//   EN         - run request, checked in IDLE and at each window end
//   WIN, COUNT - window length minus 1 (slots) and pulses per window, latched at window start
//   PULSE_OUT  - pulse train, high for the first DIV/2 cycles of each firing slot
//   WIN_STRB   - one-CLK strobe on the first cycle of each window
//   EMITTED    - pulses emitted in the last completed window
//   SAT        - COUNT exceeded WIN+1 for the current window and was clamped
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int DIV = DEF_DIV,
  parameter int W   = DEF_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic [W-1:0] WIN,
  input  logic [W-1:0] COUNT,
  output logic         PULSE_OUT,
  output logic         WIN_STRB,
  output logic [W-1:0] EMITTED,
  output logic         SAT
);

  localparam int ACC_W = acc_width(W);

  state_t           state;
  logic [W-1:0]     win_l;
  logic [W-1:0]     count_l;
  logic [W-1:0]     slot;
  logic [ACC_W-1:0] acc;
  logic [W-1:0]     fired;
  logic             fire;      // current slot fires

  logic tick_wrap;
  logic first_half;
  logic slot_start;

  tick_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (state == RUN),
    .tick_wrap (tick_wrap),
    .first_half(first_half),
    .slot_start(slot_start)
  );

  // DDA step for the next slot inside the running window.
  logic [ACC_W-1:0] run_sum;
  logic [ACC_W-1:0] run_span;
  logic             run_fire;
  logic [ACC_W-1:0] run_acc;

  // Values for a fresh window taken straight from the live inputs; acc starts at 0,
  // so slot 0's sum is just the clamped count.
  logic [ACC_W-1:0] new_span;
  logic             new_sat;
  logic [W-1:0]     new_count;
  logic [ACC_W-1:0] new_sum;
  logic             new_fire;
  logic [ACC_W-1:0] new_acc;

  logic window_end;
  logic do_start;

  always_comb begin
    run_sum  = acc + ACC_W'(count_l);
    run_span = ACC_W'(win_l) + ACC_W'(1);
    run_fire = (run_sum >= run_span);
    run_acc  = run_fire ? (run_sum - run_span) : run_sum;

    new_span  = ACC_W'(WIN) + ACC_W'(1);
    new_sat   = (ACC_W'(COUNT) > new_span);
    // When clamping, WIN+1 < COUNT <= 2^W-1, so it fits in W bits.
    new_count = new_sat ? new_span[W-1:0] : COUNT;
    new_sum   = ACC_W'(new_count);
    new_fire  = (new_sum >= new_span);
    new_acc   = new_fire ? (new_sum - new_span) : new_sum;

    window_end = (state == RUN) && tick_wrap && (slot == win_l);
    do_start   = EN && ((state == IDLE) || window_end);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      win_l   <= '0;
      count_l <= '0;
      slot    <= '0;
      acc     <= '0;
      fired   <= '0;
      fire    <= 1'b0;
      EMITTED <= '0;
      SAT     <= 1'b0;
    end else begin
      // fired already includes the final slot's fire, since it is counted on slot entry.
      if (window_end) begin
        EMITTED <= fired;
      end

      if (do_start) begin
        state   <= RUN;
        win_l   <= WIN;
        count_l <= new_count;
        SAT     <= new_sat;
        slot    <= '0;
        acc     <= new_acc;
        fire    <= new_fire;
        fired   <= W'(new_fire);
      end else if (window_end) begin
        state <= IDLE;
        slot  <= '0;
        acc   <= '0;
        fire  <= 1'b0;
        fired <= '0;
      end else if ((state == RUN) && tick_wrap) begin
        slot  <= slot + W'(1);
        acc   <= run_acc;
        fire  <= run_fire;
        fired <= fired + W'(run_fire);
      end
    end
  end

  // Both decodes use registered state only; no input reaches them combinationally.
  assign PULSE_OUT = (state == RUN) && fire && first_half;
  assign WIN_STRB  = (state == RUN) && (slot == '0) && slot_start;

endmodule

// File: tb/tb_pulse_train_gen.sv
module tb_pulse_train_gen;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic [7:0] WIN;
  logic [7:0] COUNT;
  logic       PULSE_OUT;
  logic       WIN_STRB;
  logic [7:0] EMITTED;
  logic       SAT;

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-derived pulse maps for 10-slot, DIV=4 windows: nibble s = slot s, 4'h3 = high on ticks 0,1.
  localparam logic [39:0] P_SLOTS_369   = 40'h3003003000;  // COUNT=3
  localparam logic [39:0] P_SLOTS_ODD   = 40'h3030303030;  // COUNT=5
  localparam logic [39:0] P_SLOTS_ALL   = 40'h3333333333;  // COUNT clamped to 10
  localparam logic [39:0] S_ONE_WINDOW  = 40'h0000000001;
  localparam logic [39:0] S_WIN0_STRB   = 40'h1111111111;  // WIN=0: 4-CLK windows

  always #5 CLK = ~CLK;

  pulse_train_gen #(
    .DIV(4),
    .W  (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .WIN      (WIN),
    .COUNT    (COUNT),
    .PULSE_OUT(PULSE_OUT),
    .WIN_STRB (WIN_STRB),
    .EMITTED  (EMITTED),
    .SAT      (SAT)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    EN  = 1'b0;
    step();
    RST = 1'b0;
  endtask

  // EN sampled on the next edge; returns at window cycle 0.
  task automatic start_run();
    EN = 1'b1;
    step();
  endtask

  // Records 40 cycles of PULSE_OUT/WIN_STRB; optionally changes COUNT/EN after sampling cycle chg_cyc.
  task automatic capture(input int chg_cyc, input logic [7:0] chg_count, input logic chg_en,
                         output logic [39:0] p, output logic [39:0] s);
    p = '0;
    s = '0;
    for (int c = 0; c < 40; c++) begin
      p[c] = PULSE_OUT;
      s[c] = WIN_STRB;
      if (c == chg_cyc) begin
        COUNT = chg_count;
        EN    = chg_en;
      end
      step();
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b1; WIN = 8'd9; COUNT = 8'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({PULSE_OUT, WIN_STRB, SAT, EMITTED} !== 11'h0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got %h, expected 000", i, {PULSE_OUT, WIN_STRB, SAT, EMITTED});
      end
    end
    RST = 1'b0;
    n_checks++;
    if ({PULSE_OUT, WIN_STRB, SAT, EMITTED} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_release: got %h, expected 000", {PULSE_OUT, WIN_STRB, SAT, EMITTED});
    end
    step();
    n_checks++;
    if (WIN_STRB !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_strb: got %b, expected 1", WIN_STRB);
    end
  endtask

  task automatic test_nominal();
    logic [39:0] p, s;
    do_reset();
    WIN = 8'd9; COUNT = 8'd3;
    start_run();
    n_checks++;
    if ({SAT, EMITTED} !== 9'h0) begin
      n_fail++;
      $display("FAIL nominal_start: got SAT/EMITTED %h, expected 000", {SAT, EMITTED});
    end
    capture(-1, 8'd3, 1'b1, p, s);
    n_checks++;
    if (p !== P_SLOTS_369) begin
      n_fail++;
      $display("FAIL nominal_pulses: got %h, expected %h", p, P_SLOTS_369);
    end
    n_checks++;
    if (s !== S_ONE_WINDOW) begin
      n_fail++;
      $display("FAIL nominal_strb: got %h, expected %h", s, S_ONE_WINDOW);
    end
    n_checks++;
    if (EMITTED !== 8'd3 || SAT !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_emitted: got EMITTED=%0d SAT=%b, expected 3 0", EMITTED, SAT);
    end
  endtask

  // Continues straight from test_nominal's running window.
  task automatic test_back_to_back();
    logic [39:0] p, s;
    capture(-1, 8'd3, 1'b1, p, s);
    n_checks++;
    if (p !== P_SLOTS_369 || s !== S_ONE_WINDOW) begin
      n_fail++;
      $display("FAIL b2b_window: got pulses %h strb %h, expected %h %h", p, s, P_SLOTS_369, S_ONE_WINDOW);
    end
    n_checks++;
    if (WIN_STRB !== 1'b1 || EMITTED !== 8'd3) begin
      n_fail++;
      $display("FAIL b2b_boundary: got STRB=%b EMITTED=%0d, expected 1 3", WIN_STRB, EMITTED);
    end
  endtask

  task automatic test_saturation();
    logic [39:0] p, s;
    do_reset();
    WIN = 8'd9; COUNT = 8'd12;
    start_run();
    n_checks++;
    if (SAT !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_flag: got %b, expected 1", SAT);
    end
    capture(-1, 8'd12, 1'b1, p, s);
    n_checks++;
    if (p !== P_SLOTS_ALL) begin
      n_fail++;
      $display("FAIL sat_pulses: got %h, expected %h", p, P_SLOTS_ALL);
    end
    n_checks++;
    if (EMITTED !== 8'd10 || SAT !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_emitted: got EMITTED=%0d SAT=%b, expected 10 1", EMITTED, SAT);
    end
  endtask

  task automatic test_mid_change();
    logic [39:0] p, s;
    do_reset();
    WIN = 8'd9; COUNT = 8'd3;
    start_run();
    capture(16, 8'd5, 1'b1, p, s);
    n_checks++;
    if (p !== P_SLOTS_369 || EMITTED !== 8'd3) begin
      n_fail++;
      $display("FAIL midchg_first: got pulses %h EMITTED=%0d, expected %h 3", p, EMITTED, P_SLOTS_369);
    end
    capture(-1, 8'd5, 1'b1, p, s);
    n_checks++;
    if (p !== P_SLOTS_ODD) begin
      n_fail++;
      $display("FAIL midchg_second: got %h, expected %h", p, P_SLOTS_ODD);
    end
    n_checks++;
    if (EMITTED !== 8'd5) begin
      n_fail++;
      $display("FAIL midchg_emitted: got %0d, expected 5", EMITTED);
    end
  endtask

  task automatic test_count_zero();
    logic [39:0] p, s;
    do_reset();
    WIN = 8'd9; COUNT = 8'd3;
    start_run();
    capture(1, 8'd0, 1'b1, p, s);
    n_checks++;
    if (p !== P_SLOTS_369 || EMITTED !== 8'd3) begin
      n_fail++;
      $display("FAIL zero_prev: got pulses %h EMITTED=%0d, expected %h 3", p, EMITTED, P_SLOTS_369);
    end
    capture(-1, 8'd0, 1'b1, p, s);
    n_checks++;
    if (p !== 40'h0 || s !== S_ONE_WINDOW || EMITTED !== 8'd0) begin
      n_fail++;
      $display("FAIL zero_window: got pulses %h strb %h EMITTED=%0d, expected 0 %h 0", p, s, EMITTED, S_ONE_WINDOW);
    end
  endtask

  task automatic test_win_zero();
    logic [39:0] p, s;
    do_reset();
    WIN = 8'd0; COUNT = 8'd5;
    start_run();
    n_checks++;
    if (SAT !== 1'b1) begin
      n_fail++;
      $display("FAIL win0_sat: got %b, expected 1", SAT);
    end
    capture(-1, 8'd5, 1'b1, p, s);
    n_checks++;
    if (p !== P_SLOTS_ALL || s !== S_WIN0_STRB) begin
      n_fail++;
      $display("FAIL win0_train: got pulses %h strb %h, expected %h %h", p, s, P_SLOTS_ALL, S_WIN0_STRB);
    end
    n_checks++;
    if (EMITTED !== 8'd1) begin
      n_fail++;
      $display("FAIL win0_emitted: got %0d, expected 1", EMITTED);
    end
  endtask

  task automatic test_en_drop();
    logic [39:0] p, s;
    do_reset();
    WIN = 8'd9; COUNT = 8'd3;
    start_run();
    capture(8, 8'd3, 1'b0, p, s);
    n_checks++;
    if (p !== P_SLOTS_369 || s !== S_ONE_WINDOW) begin
      n_fail++;
      $display("FAIL endrop_window: got pulses %h strb %h, expected %h %h", p, s, P_SLOTS_369, S_ONE_WINDOW);
    end
    n_checks++;
    if (EMITTED !== 8'd3) begin
      n_fail++;
      $display("FAIL endrop_emitted: got %0d, expected 3", EMITTED);
    end
    capture(-1, 8'd3, 1'b0, p, s);
    n_checks++;
    if (p !== 40'h0 || s !== 40'h0 || EMITTED !== 8'd3) begin
      n_fail++;
      $display("FAIL endrop_idle: got pulses %h strb %h EMITTED=%0d, expected 0 0 3", p, s, EMITTED);
    end
  endtask

  task automatic test_rst_mid();
    logic [39:0] p, s;
    do_reset();
    WIN = 8'd9; COUNT = 8'd12;
    start_run();
    repeat (20) step();
    n_checks++;
    if (PULSE_OUT !== 1'b1 || SAT !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_before: got PULSE=%b SAT=%b, expected 1 1", PULSE_OUT, SAT);
    end
    RST = 1'b1;
    step();
    n_checks++;
    if ({PULSE_OUT, WIN_STRB, SAT, EMITTED} !== 11'h0) begin
      n_fail++;
      $display("FAIL rstmid_after: got %h, expected 000", {PULSE_OUT, WIN_STRB, SAT, EMITTED});
    end
    RST = 1'b0;
    EN  = 1'b0;
    capture(-1, 8'd12, 1'b0, p, s);
    n_checks++;
    if (p !== 40'h0 || s !== 40'h0 || EMITTED !== 8'd0) begin
      n_fail++;
      $display("FAIL rstmid_idle: got pulses %h strb %h EMITTED=%0d, expected 0 0 0", p, s, EMITTED);
    end
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; WIN = '0; COUNT = '0;
    test_reset();
    test_nominal();
    test_back_to_back();
    test_saturation();
    test_mid_change();
    test_count_zero();
    test_win_zero();
    test_en_drop();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
